// File: rtl/bht_pkg.sv
// Shared BHT definitions used by the BHT and its commit-side update queue.
package bht_pkg;

   localparam int unsigned BHT_IDX_W   = 10;
   localparam int unsigned BHT_ENTRIES = 1024;

   typedef struct packed {
      logic [BHT_IDX_W-1:0] idx;
      logic                 dir;
   } bht_upd_t;

endpackage

// File: rtl/bht_uq_ram.sv
// Storage for the BHT update queue: DEPTH x WIDTH, two write ports, one
// asynchronous read port. No reset; contents are don't-care until written.
module bht_uq_ram #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 11
) (
   input  logic                     clock,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] waddr0,
   input  logic [WIDTH-1:0]         wdata0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr1,
   input  logic [WIDTH-1:0]         wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Two writes per cycle; addresses never collide (wp and wp+1).
   always_ff @(posedge clock) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bht_update_queue.sv
// Commit-side BHT update queue: accepts up to two retired branch outcomes per
// cycle in program order and drains one per cycle onto the BHT shift-in port.
// Optional macro BHT_UPD_BYPASS_EN: when the queue is empty and the BHT port
// is free, the oldest pushing slot goes straight to the port in the same cycle.
module bht_update_queue
   import bht_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = BHT_IDX_W,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             retire_vld0_i,
   input  logic [IDX_W-1:0] retire_idx0_i,
   input  logic             retire_dir0_i,
   input  logic             retire_vld1_i,
   input  logic [IDX_W-1:0] retire_idx1_i,
   input  logic             retire_dir1_i,
   output logic             upd_rdy_o,
   input  logic             bht_hold_i,
   output logic [IDX_W-1:0] bht_wt_index_o,
   output logic             bht_brdir_o,
   output logic             bht_brdir_se_o,
   output logic [CNT_W-1:0] q_count_o,
   output logic             ovf_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wp, rp;
   logic [CNT_W-1:0] count;
   logic             ovf;

   bht_upd_t slot0, slot1, head, port;
   bht_upd_t wdata0, wdata1;
   logic     we0, we1;
   logic     any_vld, accept, bypass, rdy, npop;
   logic [1:0] npush;

   bht_uq_ram #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(bht_upd_t))
   ) u_ram (
      .clock  (clock),
      .we0    (we0),
      .waddr0 (wp),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (wp + PTR_W'(1)),
      .wdata1 (wdata1),
      .raddr  (rp),
      .rdata  (head)
   );

   // Push acceptance, compaction onto wp/wp+1, and BHT port drive.
   always_comb begin
      slot0   = '{idx: retire_idx0_i, dir: retire_dir0_i};
      slot1   = '{idx: retire_idx1_i, dir: retire_dir1_i};
      rdy     = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
      any_vld = retire_vld0_i || retire_vld1_i;
      accept  = any_vld && rdy;
`ifdef BHT_UPD_BYPASS_EN
      bypass  = accept && (count == '0) && !bht_hold_i;
`else
      bypass  = 1'b0;
`endif
      we0    = 1'b0;
      we1    = 1'b0;
      wdata0 = slot0;
      wdata1 = slot1;
      npush  = 2'd0;
      if (accept) begin
         if (bypass) begin
            // Oldest slot goes straight out; only a younger companion is stored.
            if (retire_vld0_i && retire_vld1_i) begin
               we0    = 1'b1;
               wdata0 = slot1;
               npush  = 2'd1;
            end
         end else if (retire_vld0_i && retire_vld1_i) begin
            we0   = 1'b1;
            we1   = 1'b1;
            npush = 2'd2;
         end else begin
            we0    = 1'b1;
            wdata0 = retire_vld0_i ? slot0 : slot1;
            npush  = 2'd1;
         end
      end

      npop           = (count != '0) && !bht_hold_i;
      port           = '0;
      bht_brdir_se_o = 1'b0;
      if (bypass) begin
         port           = retire_vld0_i ? slot0 : slot1;
         bht_brdir_se_o = 1'b1;
      end else if (count != '0) begin
         port           = head;
         bht_brdir_se_o = !bht_hold_i;
      end
   end

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clock) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         wp    <= wp + PTR_W'(npush);
         rp    <= rp + PTR_W'(npop);
         count <= count + CNT_W'(npush) - CNT_W'(npop);
         if (any_vld && !rdy) ovf <= 1'b1;
      end
   end

   assign upd_rdy_o      = rdy;
   assign bht_wt_index_o = port.idx;
   assign bht_brdir_o    = port.dir;
   assign q_count_o      = count;
   assign ovf_o          = ovf;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue with a program-order scoreboard and an
// independent occupancy/overflow model.
module tb_bht_update_queue;

   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       vld0 = 1'b0, vld1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0, hold = 1'b0;
   logic [9:0] idx0 = '0, idx1 = '0;
   logic       upd_rdy, se, brdir, ovf;
   logic [9:0] windex;
   logic [3:0] qcount;

   int ncomp = 0;
   int nfail = 0;
   int mcount = 0;
   logic movf = 1'b0;
   logic [10:0] sb [$];

   always #5 clock = ~clock;

   bht_update_queue #(.DEPTH(8), .IDX_W(10), .CNT_W(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .retire_vld0_i  (vld0),
      .retire_idx0_i  (idx0),
      .retire_dir0_i  (dir0),
      .retire_vld1_i  (vld1),
      .retire_idx1_i  (idx1),
      .retire_dir1_i  (dir1),
      .upd_rdy_o      (upd_rdy),
      .bht_hold_i     (hold),
      .bht_wt_index_o (windex),
      .bht_brdir_o    (brdir),
      .bht_brdir_se_o (se),
      .q_count_o      (qcount),
      .ovf_o          (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_push(input logic v0, input logic [9:0] i0, input logic d0,
                           input logic v1, input logic [9:0] i1, input logic d1);
      vld0 = v0; idx0 = i0; dir0 = d0;
      vld1 = v1; idx1 = i1; dir1 = d1;
   endtask

   // One clock: model this cycle, compare at negedge, advance past posedge.
   task automatic tick();
      logic any, acc, byp, exp_se, exp_rdy;
      logic [10:0] e;
      int npush_m, npop_m;
      any     = vld0 || vld1;
      exp_rdy = (DEPTH - mcount) >= 2;
      acc     = any && exp_rdy;
      byp     = 1'b0;
`ifdef BHT_UPD_BYPASS_EN
      byp     = acc && (mcount == 0) && !hold;
`endif
      if (acc) begin
         if (vld0) sb.push_back({idx0, dir0});
         if (vld1) sb.push_back({idx1, dir1});
      end
      npush_m = acc ? (int'(vld0) + int'(vld1) - int'(byp)) : 0;
      npop_m  = (mcount != 0 && !hold) ? 1 : 0;
      exp_se  = (npop_m == 1) || byp;
      @(negedge clock);
      check("q_count", 32'(qcount), 32'(mcount));
      check("upd_rdy", 32'(upd_rdy), 32'(exp_rdy));
      check("ovf", 32'(ovf), 32'(movf));
      check("se", 32'(se), 32'(exp_se));
      if (exp_se && se) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("pop_index", 32'(windex), 32'(e[10:1]));
            check("pop_dir", 32'(brdir), 32'(e[0]));
         end
      end else if (mcount != 0 && sb.size() != 0) begin
         e = sb[0];
         check("head_index", 32'(windex), 32'(e[10:1]));
         check("head_dir", 32'(brdir), 32'(e[0]));
      end else if (mcount == 0 && !byp) begin
         check("idle_index", 32'(windex), 32'd0);
         check("idle_dir", 32'(brdir), 32'd0);
      end
      if (any && !acc) movf = 1'b1;
      mcount = mcount + npush_m - npop_m;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      set_push(0, '0, 0, 0, '0, 0);
      hold  = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset  = 1'b0;
      mcount = 0;
      movf   = 1'b0;
      sb.delete();
      @(negedge clock);
      check("rst_count", 32'(qcount), 32'd0);
      check("rst_se", 32'(se), 32'd0);
      check("rst_index", 32'(windex), 32'd0);
      check("rst_dir", 32'(brdir), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_rdy", 32'(upd_rdy), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clock);
      #1;
      do_reset();

      // Single push latency.
      set_push(1, 10'h155, 1, 0, '0, 0);
      tick();
      set_push(0, '0, 0, 0, '0, 0);
      tick();
      tick();
      check("single_count", 32'(qcount), 32'd0);

      // Dual pushes with identical and boundary indices, strict order.
      set_push(1, 10'h010, 1, 1, 10'h010, 0);
      tick();
      set_push(1, 10'h3FF, 1, 1, 10'h000, 0);
      tick();
      set_push(0, '0, 0, 0, '0, 0);
      repeat (4) tick();
      check("dual_sb_empty", 32'(sb.size()), 32'd0);

      // Fill under hold across the pointer wrap, then overflow.
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_push(1, 10'(10'h100 + 2 * i), 1'(i), 1, 10'(10'h101 + 2 * i), 1'(~i));
         tick();
      end
      check("full_count", 32'(qcount), 32'd8);
      check("full_rdy", 32'(upd_rdy), 32'd0);
      set_push(1, 10'h0AA, 1, 1, 10'h0BB, 0);
      tick();
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_count", 32'(qcount), 32'd8);
      set_push(0, '0, 0, 0, '0, 0);
      hold = 1'b0;
      repeat (8) tick();
      check("drain_count", 32'(qcount), 32'd0);
      check("drain_rdy", 32'(upd_rdy), 32'd1);

      // Count 6, simultaneous dual push and pop.
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_push(1, 10'(10'h200 + i), 1, 1, 10'(10'h280 + i), 0);
         tick();
      end
      hold = 1'b0;
      set_push(1, 10'h011, 0, 1, 10'h022, 1);
      tick();
      check("c7_count", 32'(qcount), 32'd7);
      check("c7_rdy", 32'(upd_rdy), 32'd0);
      set_push(0, '0, 0, 0, '0, 0);
      repeat (7) tick();

      // Slot 1 alone.
      set_push(0, '0, 0, 1, 10'h2A5, 1);
      tick();
      set_push(0, '0, 0, 0, '0, 0);
      repeat (2) tick();
      check("vld1_sb_empty", 32'(sb.size()), 32'd0);

      // Random traffic with random hold.
      for (int i = 0; i < 40; i++) begin
         hold = ($urandom_range(0, 3) == 0);
         set_push(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom),
                  1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom));
         tick();
      end
      set_push(0, '0, 0, 0, '0, 0);
      hold = 1'b0;
      repeat (10) tick();
      check("rand_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-stream with five entries queued.
      hold = 1'b1;
      set_push(1, 10'h001, 1, 1, 10'h002, 1);
      tick();
      tick();
      set_push(1, 10'h003, 0, 0, '0, 0);
      tick();
      check("pre_rst_count", 32'(qcount), 32'd5);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
